fineps_phase_sequencer: RTL and testbench

//  Multi-channel controller for MMCM fine phase shift (PSEN/PSINCDEC/PSDONE), sitting between

---
 rtl/fineps_pkg.sv | 6 +
 rtl/fineps_shortest_path.sv | 17 +
 rtl/fineps_phase_sequencer.sv | 153 +++++++++++++++
 tb/tb_fineps_phase_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fineps_pkg.sv
// fineps_pkg: shared types for the fine phase shift sequencer
package fineps_pkg;
    typedef enum logic [1:0] {MODE_REL, MODE_ABS, MODE_HOME, MODE_RSVD} cmd_mode_t;
    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_WAIT, S_FINISH, S_ERROR} state_t;
    typedef enum logic [1:0] {ERR_NONE, ERR_TIMEOUT, ERR_UNLOCKED, ERR_BAD_CMD} err_code_t;
endpackage

// File: rtl/fineps_shortest_path.sv
// fineps_shortest_path: shortest signed route between two positions on a ring of P steps
module fineps_shortest_path #(
    parameter int INT_STEPS_PER_PERIOD = 336,
    parameter int INT_POS_WIDTH = 16
) (
    input  logic [INT_POS_WIDTH-1:0] pos,
    input  logic [INT_POS_WIDTH-1:0] target,
    output logic                     dir,
    output logic [INT_POS_WIDTH-1:0] count
);
    localparam logic [INT_POS_WIDTH:0] P = (INT_POS_WIDTH + 1)'(INT_STEPS_PER_PERIOD);
    logic [INT_POS_WIDTH:0] d;
    assign d = target >= pos ? {1'b0, target} - {1'b0, pos} : {1'b0, target} + P - {1'b0, pos};
    // half-period tie resolves to the increment direction
    assign dir = d <= (P >> 1);
    assign count = dir ? d[INT_POS_WIDTH-1:0] : INT_POS_WIDTH'(P - d);
endmodule

// File: rtl/fineps_phase_sequencer.sv
// fineps_phase_sequencer: multi-channel MMCM fine phase shift sequencer with wrapped per-channel positions
module fineps_phase_sequencer
    import fineps_pkg::*;
#(
    parameter int INT_CHANNELS = 2,
    parameter int INT_STEPS_PER_PERIOD = 336,
    parameter int INT_POS_WIDTH = 16,
    parameter int INT_CMD_WIDTH = 16,
    parameter int INT_PSDONE_TIMEOUT = 64,
    localparam int CHW = INT_CHANNELS > 1 ? $clog2(INT_CHANNELS) : 1
) (
    input  logic                                  in_clk,
    input  logic                                  in_reset,
    input  logic                                  in_cmd_valid,
    output logic                                  out_cmd_ready,
    input  logic [CHW-1:0]                        in_cmd_channel,
    input  logic [1:0]                            in_cmd_mode,
    input  logic [INT_CMD_WIDTH-1:0]              in_cmd_value,
    input  logic [INT_CHANNELS-1:0]               in_locked,
    output logic [INT_CHANNELS-1:0]               out_psen,
    output logic [INT_CHANNELS-1:0]               out_psincdec,
    input  logic [INT_CHANNELS-1:0]               in_psdone,
    output logic [INT_CHANNELS*INT_POS_WIDTH-1:0] out_position,
    output logic                                  out_busy,
    output logic                                  out_done,
    output logic                                  out_error,
    output logic [1:0]                            out_err_code
);
    localparam int PW = INT_POS_WIDTH;
    localparam int CW = INT_CMD_WIDTH;
    localparam int RW = CW > PW ? CW : PW;
    localparam int TW = $clog2(INT_PSDONE_TIMEOUT + 1);
    localparam logic [PW:0] P = (PW + 1)'(INT_STEPS_PER_PERIOD);
    localparam logic [PW-1:0] P_MAX = PW'(INT_STEPS_PER_PERIOD - 1);
    localparam logic [CHW:0] CH_N = (CHW + 1)'(INT_CHANNELS);
    localparam logic [TW-1:0] TO = TW'(INT_PSDONE_TIMEOUT);

    state_t state, state_n;
    err_code_t err_code, err_n;
    cmd_mode_t mode;
    logic [CHW-1:0] ch;
    logic [CW-1:0] value, mag;
    logic dir, calc_dir, sp_dir, step, bad_cmd, locked, psdone;
    logic [RW-1:0] remaining, calc_cnt;
    logic [TW-1:0] timer;
    logic [PW-1:0] pos [INT_CHANNELS];
    logic [PW-1:0] pos_cur, target, sp_cnt, rem_mod;
    logic [PW:0] shifted;

    assign pos_cur = pos[ch];
    assign locked = in_locked[ch];
    assign psdone = in_psdone[ch];
    assign bad_cmd = mode == MODE_RSVD || {1'b0, ch} >= CH_N;

    // absolute target reduced mod P by restoring shift/subtract over the magnitude bits
    always_comb begin
        mag = value[CW-1] ? -value : value;
        rem_mod = '0;
        shifted = '0;
        for (int i = CW - 1; i >= 0; i--) begin
            shifted = {rem_mod, mag[i]};
            rem_mod = shifted >= P ? PW'(shifted - P) : shifted[PW-1:0];
        end
        target = mode == MODE_HOME ? '0 :
                 (value[CW-1] && rem_mod != '0) ? PW'(P - {1'b0, rem_mod}) : rem_mod;
    end

    fineps_shortest_path #(
        .INT_STEPS_PER_PERIOD(INT_STEPS_PER_PERIOD),
        .INT_POS_WIDTH(PW)
    ) u_path (
        .pos(pos_cur),
        .target(target),
        .dir(sp_dir),
        .count(sp_cnt)
    );

    assign calc_dir = mode == MODE_REL ? !value[CW-1] : sp_dir;
    assign calc_cnt = mode == MODE_REL ? RW'(mag) : RW'(sp_cnt);

    always_ff @(posedge in_clk) begin
        if (in_reset) state <= S_IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        err_n = ERR_NONE;
        step = 1'b0;
        case (state)
            S_IDLE: state_n = in_cmd_valid ? S_CALC : S_IDLE;
            S_CALC: begin
                state_n = bad_cmd ? S_ERROR : calc_cnt == '0 ? S_FINISH : S_ISSUE;
                err_n = bad_cmd ? ERR_BAD_CMD : ERR_NONE;
            end
            S_ISSUE: begin
                state_n = locked ? S_WAIT : S_ERROR;
                err_n = locked ? ERR_NONE : ERR_UNLOCKED;
            end
            S_WAIT: begin
                step = psdone;
                state_n = psdone ? (remaining == RW'(1) ? S_FINISH : S_ISSUE) :
                          (!locked || timer == TO) ? S_ERROR : S_WAIT;
                err_n = psdone ? ERR_NONE : !locked ? ERR_UNLOCKED :
                        timer == TO ? ERR_TIMEOUT : ERR_NONE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            mode <= MODE_REL;
            ch <= '0;
            value <= '0;
            dir <= 1'b0;
            remaining <= '0;
            timer <= '0;
            err_code <= ERR_NONE;
            for (int i = 0; i < INT_CHANNELS; i++) pos[i] <= '0;
        end else begin
            if (state == S_IDLE && in_cmd_valid) begin
                mode <= cmd_mode_t'(in_cmd_mode);
                ch <= in_cmd_channel;
                value <= in_cmd_value;
                err_code <= ERR_NONE;
            end
            if (state == S_CALC) begin
                dir <= calc_dir;
                remaining <= calc_cnt;
            end
            timer <= state == S_WAIT ? timer + 1'b1 : '0;
            if (step) begin
                remaining <= remaining - 1'b1;
                pos[ch] <= dir ? (pos_cur == P_MAX ? '0 : pos_cur + 1'b1) :
                                 (pos_cur == '0 ? P_MAX : pos_cur - 1'b1);
            end
            if (err_n != ERR_NONE) err_code <= err_n;
        end
    end

    assign out_cmd_ready = state == S_IDLE;
    assign out_busy = state != S_IDLE;
    assign out_done = state == S_FINISH;
    assign out_error = state == S_ERROR;
    assign out_err_code = err_code;
    assign out_psen = (state == S_ISSUE && locked) ? INT_CHANNELS'(1) << ch : '0;
    assign out_psincdec = dir ? out_psen : '0;

    always_comb begin
        for (int i = 0; i < INT_CHANNELS; i++) out_position[i*PW +: PW] = pos[i];
    end
endmodule

// File: tb/tb_fineps_phase_sequencer.sv
// tb_fineps_phase_sequencer: scoreboard bench with a 12-cycle PSDONE model and ring-arithmetic reference
module tb_fineps_phase_sequencer;
    localparam int CH = 3, P = 336, PW = 16, CW = 16, TO = 64, LAT = 12;

    logic in_clk = 1'b0, in_reset = 1'b1, in_cmd_valid = 1'b0;
    logic [1:0] in_cmd_channel = '0, in_cmd_mode = '0;
    logic [CW-1:0] in_cmd_value = '0;
    logic [CH-1:0] in_locked = '1, in_psdone, out_psen, out_psincdec;
    logic out_cmd_ready, out_busy, out_done, out_error;
    logic [1:0] out_err_code;
    logic [CH*PW-1:0] out_position;

    fineps_phase_sequencer #(
        .INT_CHANNELS(CH), .INT_STEPS_PER_PERIOD(P), .INT_POS_WIDTH(PW),
        .INT_CMD_WIDTH(CW), .INT_PSDONE_TIMEOUT(TO)
    ) dut (
        .in_clk(in_clk), .in_reset(in_reset), .in_cmd_valid(in_cmd_valid),
        .out_cmd_ready(out_cmd_ready), .in_cmd_channel(in_cmd_channel),
        .in_cmd_mode(in_cmd_mode), .in_cmd_value(in_cmd_value), .in_locked(in_locked),
        .out_psen(out_psen), .out_psincdec(out_psincdec), .in_psdone(in_psdone),
        .out_position(out_position), .out_busy(out_busy), .out_done(out_done),
        .out_error(out_error), .out_err_code(out_err_code)
    );

    always #5 in_clk = ~in_clk;

    logic [CH-1:0] ps_en = '1;
    int pend [CH];
    always @(posedge in_clk) begin
        for (int c = 0; c < CH; c++)
            pend[c] <= in_reset ? 0 : (out_psen[c] && ps_en[c]) ? LAT : pend[c] > 0 ? pend[c] - 1 : 0;
    end
    always_comb begin
        for (int c = 0; c < CH; c++) in_psdone[c] = pend[c] == 1;
    end

    typedef struct {
        bit is_err;
        logic [1:0] code;
        int ch;
        bit dir;
        int n_psen;
        logic [CH*PW-1:0] pos;
    } exp_t;

    exp_t sb [$];
    int compared = 0, mismatched = 0;
    int model_pos [CH];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [CH*PW-1:0] pack_pos();
        logic [CH*PW-1:0] r;
        for (int c = 0; c < CH; c++) r[c*PW +: PW] = PW'(model_pos[c]);
        return r;
    endfunction

    // signed step count the sequencer should take, from ring arithmetic
    function automatic int delta_of(int pos, int mode, int val);
        int t, d;
        if (mode == 0) return val;
        t = mode == 2 ? 0 : ((val % P) + P) % P;
        d = ((t - pos) % P + P) % P;
        return d <= P / 2 ? d : d - P;
    endfunction

    initial begin
        int cyc, acc_cyc, last_pd, npsen;
        bit first, prev_busy;
        exp_t e;
        cyc = 0; acc_cyc = 0; last_pd = 0; npsen = 0; first = 0; prev_busy = 0;
        forever begin
            @(negedge in_clk);
            cyc++;
            if (!in_reset) begin
                if (out_busy && !prev_busy) begin
                    acc_cyc = cyc - 1;
                    npsen = 0;
                    first = 1;
                end
                if (out_psen != '0) begin
                    if (sb.size() == 0) check("psen_unexpected", 64'(out_psen), 0);
                    else begin
                        check("psen_onehot", 64'(out_psen), 64'(1) << sb[0].ch);
                        check("psincdec", 64'(out_psincdec), sb[0].dir ? 64'(1) << sb[0].ch : 0);
                        for (int c = 0; c < CH; c++)
                            if (out_psen[c]) check("psen_before_psdone", 64'(pend[c]), 0);
                        if (first) check("first_psen_latency", 64'(cyc - acc_cyc), 2);
                        first = 0;
                        npsen++;
                    end
                end
                if (sb.size() > 0 && sb[0].ch < CH && in_psdone[sb[0].ch]) last_pd = cyc;
                if (out_done || out_error) begin
                    if (sb.size() == 0) check("unexpected_end", {62'd0, out_done, out_error}, 0);
                    else begin
                        e = sb.pop_front();
                        check("end_kind", {62'd0, out_done, out_error}, e.is_err ? 64'd1 : 64'd2);
                        check("err_code", 64'(out_err_code), 64'(e.code));
                        check("positions", 64'(out_position), 64'(e.pos));
                        check("psen_count", 64'(npsen), 64'(e.n_psen));
                        if (!e.is_err && e.n_psen > 0) check("done_latency", 64'(cyc - last_pd), 1);
                    end
                end
            end
            prev_busy = out_busy;
        end
    end

    task automatic reset_dut();
        in_reset = 1'b1;
        @(negedge in_clk);
        in_reset = 1'b0;
        sb.delete();
        for (int c = 0; c < CH; c++) model_pos[c] = 0;
    endtask

    task automatic check_reset_state();
        check("rst_ready", 64'(out_cmd_ready), 1);
        check("rst_busy", 64'(out_busy), 0);
        check("rst_psen", 64'(out_psen), 0);
        check("rst_done_error", {62'd0, out_done, out_error}, 0);
        check("rst_err_code", 64'(out_err_code), 0);
        check("rst_position", 64'(out_position), 0);
    endtask

    // kind: 0 normal, 1 PSDONE dies after k steps, 2 lock lost after k steps, 3 reset after k steps
    task automatic issue(int ch, int mode, int val, int kind, int k);
        exp_t e;
        int d, n, cnt, budget;
        bit bad;
        bad = mode == 3 || ch >= CH;
        d = bad ? 0 : delta_of(model_pos[ch], mode, val);
        n = d < 0 ? -d : d;
        e.ch = ch; e.dir = d > 0; e.is_err = bad; e.code = bad ? 2'd3 : 2'd0; e.n_psen = n;
        if (!bad && kind == 1) begin e.is_err = 1; e.code = 2'd1; e.n_psen = k + 1; n = k; end
        if (!bad && kind == 2) begin e.is_err = 1; e.code = 2'd2; e.n_psen = k; n = k; end
        if (!bad) model_pos[ch] = ((model_pos[ch] + (d < 0 ? -n : n)) % P + P) % P;
        e.pos = pack_pos();
        sb.push_back(e);
        budget = 0;
        while (!out_cmd_ready && budget < 1000) begin @(negedge in_clk); budget++; end
        in_cmd_valid = 1'b1;
        in_cmd_channel = 2'(ch);
        in_cmd_mode = 2'(mode);
        in_cmd_value = CW'(val);
        @(negedge in_clk);
        in_cmd_valid = 1'b0;
        if (kind != 0) begin
            cnt = 0; budget = 0;
            while (cnt < k && budget < 2000) begin
                @(negedge in_clk);
                budget++;
                if (in_psdone[ch]) cnt++;
            end
            if (kind == 1) ps_en[ch] = 1'b0;
            if (kind == 2) in_locked[ch] = 1'b0;
        end
        if (kind == 3) begin
            repeat (3) @(negedge in_clk);
            check("wait_busy_before_reset", 64'(out_busy), 1);
            reset_dut();
            check_reset_state();
            repeat (20) @(negedge in_clk);
        end else begin
            budget = 0;
            while (!(out_done || out_error) && budget < 20 * n + TO + 200) begin
                @(negedge in_clk);
                budget++;
            end
            check("cmd_end_seen", 64'(out_done | out_error), 1);
            if (!(out_done || out_error)) reset_dut();
            @(negedge in_clk);
            ps_en = '1;
            in_locked = '1;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ch, mode, val;
        for (int c = 0; c < CH; c++) model_pos[c] = 0;
        repeat (3) @(negedge in_clk);
        check_reset_state();
        in_reset = 1'b0;
        @(negedge in_clk);
        issue(0, 0, 5, 0, 0);
        issue(0, 0, -3, 0, 0);
        issue(0, 1, 330, 0, 0);
        issue(1, 1, 168, 0, 0);
        issue(1, 2, 0, 0, 0);
        issue(0, 0, 10, 1, 3);
        issue(0, 0, -20, 2, 4);
        issue(0, 3, 7, 0, 0);
        issue(3, 0, 5, 0, 0);
        issue(2, 1, -1, 0, 0);
        issue(2, 0, 0, 0, 0);
        issue(2, 1, 671, 0, 0);
        for (int i = 0; i < 20; i++) begin
            ch = $urandom_range(0, 3);
            mode = $urandom_range(0, 3);
            val = mode == 0 ? int'($urandom_range(0, 60)) - 30 : int'($urandom_range(0, 1400)) - 700;
            issue(ch, mode, val, 0, 0);
        end
        issue(1, 0, 12, 3, 2);
        issue(1, 0, -2, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
